// File: rtl/fp32_stream_adder.sv
// Sequential IEEE-754 binary32 adder with stb/ack handshakes on A, B and Z.
// Define FP_ADD_FTZ_EN to flush subnormal inputs and results to signed zero.
module fp32_stream_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD0, ADD1,
    NORM1, NORM2, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] EMIN  = -10'sd126;
  localparam logic signed [9:0] EZERO = -10'sd127;
  localparam logic signed [9:0] EINF  = 10'sd128;

  state_t             state_q, state_d;
  logic [31:0]        a_raw_q, a_raw_d, b_raw_q, b_raw_d, z_out_q, z_out_d;
  logic [26:0]        a_m_q, a_m_d, b_m_q, b_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic [27:0]        sum_q, sum_d;
  logic [23:0]        z_m_q, z_m_d;
  logic               guard_q, guard_d, rnd_q, rnd_d, sticky_q, sticky_d;
  logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_out_q;
  assign output_z_stb = z_stb_q;

  assign a_nan = (a_e_q == EINF) && (a_m_q != '0);
  assign b_nan = (b_e_q == EINF) && (b_m_q != '0);
  assign a_inf = (a_e_q == EINF) && (a_m_q == '0);
  assign b_inf = (b_e_q == EINF) && (b_m_q == '0);
`ifdef FP_ADD_FTZ_EN
  assign a_zero = (a_e_q == EZERO);
  assign b_zero = (b_e_q == EZERO);
`else
  assign a_zero = (a_e_q == EZERO) && (a_m_q == '0);
  assign b_zero = (b_e_q == EZERO) && (b_m_q == '0);
`endif

  always_comb begin
    state_d  = state_q;
    a_raw_d  = a_raw_q;  b_raw_d = b_raw_q;  z_out_d = z_out_q;
    a_m_d    = a_m_q;    b_m_d   = b_m_q;
    a_e_d    = a_e_q;    b_e_d   = b_e_q;    z_e_d   = z_e_q;
    a_s_d    = a_s_q;    b_s_d   = b_s_q;    z_s_d   = z_s_q;
    sum_d    = sum_q;    z_m_d   = z_m_q;
    guard_d  = guard_q;  rnd_d   = rnd_q;    sticky_d = sticky_q;
    a_ack_d  = a_ack_q;  b_ack_d = b_ack_q;  z_stb_d = z_stb_q;
    case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (input_a_stb && a_ack_q) begin
          a_raw_d = input_a;
          a_ack_d = 1'b0;
          state_d = GET_B;
        end
      end
      GET_B: begin
        b_ack_d = 1'b1;
        if (input_b_stb && b_ack_q) begin
          b_raw_d = input_b;
          b_ack_d = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        a_m_d   = {1'b0, a_raw_q[22:0], 3'b000};
        b_m_d   = {1'b0, b_raw_q[22:0], 3'b000};
        a_e_d   = $signed({2'b00, a_raw_q[30:23]}) - 10'sd127;
        b_e_d   = $signed({2'b00, b_raw_q[30:23]}) - 10'sd127;
        a_s_d   = a_raw_q[31];
        b_s_d   = b_raw_q[31];
        state_d = SPECIAL;
      end
      SPECIAL: begin
        z_stb_d = 1'b1;
        state_d = PUT_Z;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s_q != b_s_q))) z_out_d = 32'h7FC0_0000;
        else if (a_inf)             z_out_d = {a_s_q, 8'hFF, 23'd0};
        else if (b_inf)             z_out_d = {b_s_q, 8'hFF, 23'd0};
        else if (a_zero && b_zero)  z_out_d = {a_s_q & b_s_q, 31'd0};
        else if (a_zero)            z_out_d = b_raw_q;
        else if (b_zero)            z_out_d = a_raw_q;
        else begin
          z_stb_d = 1'b0;
          state_d = ALIGN;
          if (a_e_q == EZERO) a_e_d = EMIN; else a_m_d[26] = 1'b1;
          if (b_e_q == EZERO) b_e_d = EMIN; else b_m_d[26] = 1'b1;
        end
      end
      // Gaps wider than the mantissa collapse in one step to a lone sticky bit,
      // which keeps the alignment loop inside the latency bound.
      ALIGN: begin
        if (a_e_q > b_e_q) begin
          if (a_e_q - b_e_q > 10'sd26) begin
            b_m_d = {26'd0, |b_m_q};
            b_e_d = a_e_q;
          end else begin
            b_m_d = {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
            b_e_d = b_e_q + 10'sd1;
          end
        end else if (b_e_q > a_e_q) begin
          if (b_e_q - a_e_q > 10'sd26) begin
            a_m_d = {26'd0, |a_m_q};
            a_e_d = b_e_q;
          end else begin
            a_m_d = {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
            a_e_d = a_e_q + 10'sd1;
          end
        end else begin
          state_d = ADD0;
        end
      end
      ADD0: begin
        z_e_d = a_e_q;
        if (a_s_q == b_s_q) begin
          sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
          z_s_d = a_s_q;
        end else if (a_m_q >= b_m_q) begin
          sum_d = {1'b0, a_m_q} - {1'b0, b_m_q};
          z_s_d = a_s_q;
        end else begin
          sum_d = {1'b0, b_m_q} - {1'b0, a_m_q};
          z_s_d = b_s_q;
        end
        state_d = ADD1;
      end
      // Exact cancellation is emitted directly so it never walks NORM1 down to EMIN.
      ADD1: begin
        if (sum_q == '0) begin
          z_out_d = '0;
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end else begin
          if (sum_q[27]) begin
            z_m_d    = sum_q[27:4];
            guard_d  = sum_q[3];
            rnd_d    = sum_q[2];
            sticky_d = sum_q[1] | sum_q[0];
            z_e_d    = z_e_q + 10'sd1;
          end else begin
            z_m_d    = sum_q[26:3];
            guard_d  = sum_q[2];
            rnd_d    = sum_q[1];
            sticky_d = sum_q[0];
          end
          state_d = NORM1;
        end
      end
      NORM1: begin
        if (!z_m_q[23] && (z_e_q > EMIN)) begin
          z_m_d   = {z_m_q[22:0], guard_q};
          guard_d = rnd_q;
          rnd_d   = 1'b0;
          z_e_d   = z_e_q - 10'sd1;
        end else begin
`ifdef FP_ADD_FTZ_EN
          state_d = ROUND;
`else
          state_d = NORM2;
`endif
        end
      end
`ifndef FP_ADD_FTZ_EN
      NORM2: begin
        if (z_e_q < EMIN) begin
          z_m_d    = {1'b0, z_m_q[23:1]};
          guard_d  = z_m_q[0];
          rnd_d    = guard_q;
          sticky_d = sticky_q | rnd_q;
          z_e_d    = z_e_q + 10'sd1;
        end else begin
          state_d = ROUND;
        end
      end
`endif
      ROUND: begin
        if (guard_q && (rnd_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFF_FFFF) z_e_d = z_e_q + 10'sd1;
        end
        state_d = PACK;
      end
      PACK: begin
        if (z_e_q > 10'sd127)
          z_out_d = {z_s_q, 8'hFF, 23'd0};
        else if ((z_e_q == EMIN) && !z_m_q[23])
`ifdef FP_ADD_FTZ_EN
          z_out_d = {z_s_q, 31'd0};
`else
          z_out_d = {z_s_q, 8'h00, z_m_q[22:0]};
`endif
        else
          z_out_d = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
        z_stb_d = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= GET_A;
      a_raw_q <= '0; b_raw_q <= '0; z_out_q <= '0;
      a_m_q   <= '0; b_m_q   <= '0;
      a_e_q   <= '0; b_e_q   <= '0; z_e_q   <= '0;
      a_s_q   <= 1'b0; b_s_q <= 1'b0; z_s_q <= 1'b0;
      sum_q   <= '0; z_m_q   <= '0;
      guard_q <= 1'b0; rnd_q <= 1'b0; sticky_q <= 1'b0;
      a_ack_q <= 1'b0; b_ack_q <= 1'b0; z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_raw_q <= a_raw_d; b_raw_q <= b_raw_d; z_out_q <= z_out_d;
      a_m_q   <= a_m_d;   b_m_q   <= b_m_d;
      a_e_q   <= a_e_d;   b_e_q   <= b_e_d;   z_e_q   <= z_e_d;
      a_s_q   <= a_s_d;   b_s_q   <= b_s_d;   z_s_q   <= z_s_d;
      sum_q   <= sum_d;   z_m_q   <= z_m_d;
      guard_q <= guard_d; rnd_q <= rnd_d; sticky_q <= sticky_d;
      a_ack_q <= a_ack_d; b_ack_q <= b_ack_d; z_stb_q <= z_stb_d;
    end
  end

endmodule

// File: tb/tb_fp32_stream_adder.sv
// Self-checking bench for fp32_stream_adder against an exact-integer binary32 addition model.
module tb_fp32_stream_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = '0, input_b = '0;
  logic        input_a_stb = 1'b0, input_b_stb = 1'b0, output_z_ack = 1'b0;
  logic        input_a_ack, input_b_ack, output_z_stb;
  logic [31:0] output_z;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  fp32_stream_adder dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Value of a finite operand as an integer multiple of 2^-149.
  function automatic logic [287:0] mag(input logic [31:0] x);
    logic [287:0] m;
    m = {264'd0, (x[30:23] != 8'd0), x[22:0]};
    if (x[30:23] != 8'd0) m = m << (x[30:23] - 8'd1);
    return m;
  endfunction

  function automatic bit is_zero(input logic [31:0] x);
`ifdef FP_ADD_FTZ_EN
    return x[30:23] == 8'd0;
`else
    return x[30:0] == 31'd0;
`endif
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) || is_zero(a) || is_zero(b);
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [287:0] ma, mb, s, rem, half, keep;
    logic sz;
    bit a_nan, b_nan, a_inf, b_inf;
    int p, sh, ex;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
    if (is_zero(a)) return b;
    if (is_zero(b)) return a;
    ma = mag(a);
    mb = mag(b);
    if (a[31] == b[31]) begin s = ma + mb; sz = a[31]; end
    else if (ma >= mb)  begin s = ma - mb; sz = a[31]; end
    else                begin s = mb - ma; sz = b[31]; end
    if (s == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 288; i++) if (s[i]) p = i;
    if (p <= 23) begin
`ifdef FP_ADD_FTZ_EN
      if (p < 23) return {sz, 31'd0};
`endif
      return {sz, s[30:0]};
    end
    sh   = p - 23;
    keep = s >> sh;
    rem  = s & ((288'd1 << sh) - 288'd1);
    half = 288'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && keep[0])) keep = keep + 288'd1;
    if (keep[24]) begin keep = keep >> 1; sh++; end
    ex = sh + 1;
    if (ex >= 255) return {sz, 8'hFF, 23'd0};
    return {sz, ex[7:0], keep[22:0]};
  endfunction

  task automatic send(input bit is_b, input logic [31:0] v, input string tag);
    bit ok = 0;
    @(negedge clk);
    input_a_stb = 1'b0;
    if (is_b) begin input_b = v; input_b_stb = 1'b1; end
    else      begin input_a = v; input_a_stb = 1'b1; end
    for (int i = 0; i < 50 && !ok; i++) begin
      if (is_b ? input_b_ack : input_a_ack) begin
        if (!is_b) check({tag, "_b_ack_in_get_a"}, {31'd0, input_b_ack}, 32'd0);
        @(posedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, is_b ? "_b_accept" : "_a_accept"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic get_result(input logic [31:0] exp_z, input bit special, input int hold, input string tag);
    bit ok = 0;
    bit stable = 1;
    int k = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      input_b_stb = 1'b0;
      k++;
      if (output_z_stb) ok = 1;
    end
    check({tag, "_latency"}, {31'd0, ok && (k <= (special ? 4 : 40))}, 32'd1);
    check({tag, "_z"}, output_z, exp_z);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (output_z !== exp_z || output_z_stb !== 1'b1) stable = 0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, {31'd0, stable}, 32'd1);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    check({tag, "_stb_clear"}, {31'd0, output_z_stb}, 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
    send(1'b0, a, tag);
    send(1'b1, b, tag);
    get_result(ref_add(a, b), is_special(a, b), hold, tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  ea;
    int          cat;

    repeat (3) @(negedge clk);
    check("reset_flags", {29'd0, input_a_ack, input_b_ack, output_z_stb}, 32'd0);
    check("reset_z", output_z, 32'd0);
    rst = 1'b1;

    run_op(32'h3F80_0000, 32'h4000_0000, 10, "one_plus_two");
    check("one_plus_two_model", ref_add(32'h3F80_0000, 32'h4000_0000), 32'h4040_0000);
    run_op(32'h3F80_0000, 32'hBF80_0000, 0, "cancel");
    run_op(32'h8000_0000, 32'h8000_0000, 0, "neg_zeros");
    run_op(32'h8000_0000, 32'h0000_0000, 0, "mixed_zeros");
    run_op(32'h7F80_0000, 32'hFF80_0000, 0, "inf_minus_inf");
    run_op(32'h7F80_0000, 32'h3F80_0000, 0, "inf_plus_one");
    run_op(32'h7FC0_1234, 32'h3F80_0000, 0, "nan_in");
    run_op(32'h0000_0000, 32'hC123_4567, 0, "zero_plus_x");
    run_op(32'h3F80_0000, 32'h3380_0000, 0, "round_tie_even");
    run_op(32'h3F80_0000, 32'h3380_0001, 0, "round_up");
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 0, "overflow");
    run_op(32'h0000_0001, 32'h0000_0001, 0, "sub_sum");
    run_op(32'h0080_0000, 32'h8000_0001, 0, "min_norm_minus_sub");
    run_op(32'h7F00_0000, 32'h0000_0001, 0, "huge_gap");
    run_op(32'h3F80_0000, 32'hBF7F_FFFF, 0, "deep_normalize");

    // Abort mid-alignment: exponent gap of 23 keeps the FSM shifting.
    send(1'b0, 32'h4B00_0000, "rst_mid");
    send(1'b1, 32'h3F80_0000, "rst_mid");
    @(negedge clk);
    input_b_stb = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_flags", {29'd0, input_a_ack, input_b_ack, output_z_stb}, 32'd0);
    check("rst_mid_z", output_z, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_no_result", {31'd0, output_z_stb}, 32'd0);
    run_op(32'h4B00_0000, 32'h3F80_0000, 0, "after_reset");

    for (int n = 0; n < 300; n++) begin
      cat = $urandom_range(0, 3);
      ra  = $urandom;
      rb  = $urandom;
      case (cat)
        1: begin
          ea = ra[30:23] + 8'($urandom_range(0, 2));
          rb = {~ra[31], ea, rb[22:0]};
        end
        2: begin
          ra[30:23] = 8'($urandom_range(0, 3));
          rb[30:23] = 8'($urandom_range(0, 3));
        end
        3: begin
          ea = 8'($urandom_range(40, 200));
          ra[30:23] = ea;
          rb[30:23] = ea - 8'($urandom_range(0, 30));
        end
        default: ;
      endcase
      run_op(ra, rb, (n % 37 == 0) ? 3 : 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
